// File: rtl/functw_arb.sv
// Round-robin arbiter sharing one combinational FUNCTW among NCH ADPCM channels.
// Optional FUNCTW_IMASK_EN masks the granted I code to the rate's code width.
module functw_arb #(
  parameter int NCH = 4,
  parameter int CHW = 2
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [NCH-1:0]   REQ,
  input  logic [5*NCH-1:0] I_BUS,
  input  logic [2*NCH-1:0] RATE_BUS,
  output logic [NCH-1:0]   GNT,
  output logic [4:0]       FI,
  output logic [1:0]       FRATE,
  input  logic [11:0]      FWI,
  output logic [11:0]      WI_OUT,
  output logic [CHW-1:0]   WI_CH,
  output logic             WI_VALID,
  input  logic             WI_READY
);

  // state | meaning
  // IDLE  | no result held; arbitrate every cycle
  // LOAD  | FI/FRATE driving FUNCTW; capture FWI next edge
  // OUT   | result valid; hold until WI_READY, then re-arbitrate
  typedef enum logic [1:0] {IDLE, LOAD, OUT} state_t;

  state_t         state;
  logic [CHW-1:0] rr_ptr;
  logic           arb_en;
  logic           win_found;
  logic [CHW-1:0] win_idx;
  logic [CHW-1:0] cand;
  logic [4:0]     win_i;
  logic [1:0]     win_rate;
  logic [4:0]     fi_next;
  logic [CHW-1:0] ptr_next;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int n = 0; n < NCH; n++) begin
      cand = CHW'((int'(rr_ptr) + n) % NCH);
      if (!win_found && REQ[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign win_i    = I_BUS[int'(win_idx)*5 +: 5];
  assign win_rate = RATE_BUS[int'(win_idx)*2 +: 2];
  assign arb_en   = (state == IDLE) || ((state == OUT) && WI_READY);
  assign ptr_next = (int'(win_idx) == NCH-1) ? '0 : win_idx + 1'b1;

`ifdef FUNCTW_IMASK_EN
  always_comb begin
    fi_next = win_i;
    case (win_rate)
      2'b00:   fi_next = win_i;
      2'b01:   fi_next = {1'b0, win_i[3:0]};
      2'b10:   fi_next = {2'b00, win_i[2:0]};
      default: fi_next = {3'b000, win_i[1:0]};
    endcase
  end
`else
  assign fi_next = win_i;
`endif

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      GNT      <= '0;
      FI       <= '0;
      FRATE    <= '0;
      WI_OUT   <= '0;
      WI_CH    <= '0;
      WI_VALID <= 1'b0;
    end else begin
      GNT <= '0;
      case (state)
        LOAD: begin
          WI_OUT   <= FWI;
          WI_VALID <= 1'b1;
          state    <= OUT;
        end
        default: begin
          // OUT without WI_READY falls through arb_en=0 and holds everything
          if (arb_en) begin
            WI_VALID <= 1'b0;
            if (win_found) begin
              GNT    <= {{(NCH-1){1'b0}}, 1'b1} << win_idx;
              FI     <= fi_next;
              FRATE  <= win_rate;
              WI_CH  <= win_idx;
              rr_ptr <= ptr_next;
              state  <= LOAD;
            end else begin
              state  <= IDLE;
            end
          end
        end
      endcase
    end
  end

endmodule
